stream_rr_arbiter: RTL and testbench
====================================

Name: stream_rr_arbiter

Overview:
- N-input round-robin arbiter that shares one valid/ready data channel among NREQ requesters, with packet locking on a last flag.
- Sits in front of the shared pipe/skid-buffer stage; its output port drives that stage's input handshake.
- Output is registered, with a one-entry internal skid buffer, so an upstream beat is never dropped when the downstream stalls.

Parameters:
- NREQ, 4, number of requesters (2..16; need not be a power of 2).
- DWIDTH, 8, data width per beat.
- IW, 2, grant index width; must satisfy 2**IW >= NREQ.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  synchronous active-low reset.
- s_data  input  NREQ*DWIDTH  requester data; requester i uses bits [i*DWIDTH +: DWIDTH].
- s_valid  input  NREQ  per-requester beat valid.
- s_last  input  NREQ  per-requester last-beat-of-packet flag; qualified by s_valid.
- s_ready  output  NREQ  per-requester accept; combinational from registered state only.
- m_data  output  DWIDTH  shared channel data (registered).
- m_valid  output  1  shared channel valid (registered).
- m_last  output  1  last flag of the beat on m_data (registered).
- m_ready  input  1  downstream accept.
- m_grant  output  IW  index of the currently or most recently granted requester (registered).
- busy  output  1  high while in LOCK (registered).

Behaviour:
- Reset (rstn low at a clock edge): state=IDLE, rr pointer=0, m_grant=0, busy=0, m_valid=0, m_last=0, m_data=0, skid empty, s_ready=all 0. Reset mid-packet discards the output register, the skid entry and the lock.
- Upstream transfer on requester i: s_valid[i] & s_ready[i]. Downstream transfer: m_valid & m_ready.
- s_ready[i] = (state==LOCK) & (m_grant==i) & !skid_full. At most one bit is high.
- State IDLE:
  - If any s_valid bit is high, select the first requester at or after the rr pointer, scanning upward and wrapping from NREQ-1 to 0.
  - On the next edge: m_grant <= selected index, state <= LOCK, busy <= 1.
  - No beat is accepted in IDLE. Arbitration latency is 1 cycle.
- State LOCK:
  - Accept beats only from m_grant. The lock holds even if that requester drops s_valid mid-packet; other requesters wait.
  - When a beat with s_last=1 is accepted: state <= IDLE, busy <= 0, pointer <= (m_grant+1) mod NREQ.
  - Result: exactly one IDLE bubble cycle between packets.
- Output register and skid, on each edge:
  - Output register empty or m_ready=1: load from skid if skid is full (skid empties), else from the accepted beat if any. If neither is available, m_valid <= 0.
  - Output register full, m_ready=0, and a beat accepted: beat goes into the skid (skid_full <= 1).
  - Skid full with m_ready=1: skid moves to the output register. A beat accepted in the same cycle cannot occur, because s_ready=0 while the skid is full.
  - m_data and m_last hold while m_valid=1 and m_ready=0.
- Latency: accepted beat to m_valid is 1 cycle when the path is unstalled. Sustained throughput within a packet is 1 beat/cycle with m_ready held high.
- Beat order is preserved. No beat is duplicated or lost. m_last appears exactly once per packet, on the final beat.
- Single-beat packet (s_last=1 on the first beat): LOCK lasts exactly 1 accepting cycle.
- Only the granted requester's s_last is observed. Other requesters' inputs are ignored.

Test Plan:
- Reset then idle: all s_valid=0 for 10 cycles -> m_valid=0, s_ready=0000, busy=0, m_grant=0 throughout.
- Single requester: req1 sends 3-beat packet 0xA1,0xA2,0xA3 (last on 0xA3), m_ready=1 -> grant=1 one cycle after valid, m_data 0xA1..0xA3 on consecutive cycles, m_last only with 0xA3, then busy=0.
- Fairness: all 4 requesters hold 1-beat packets (data 0x10*i) continuously from reset -> grant order 0,1,2,3,0,1, each packet followed by one bubble cycle.
- Backpressure: req2 streams 0x21..0x24, m_ready low for 3 cycles mid-packet -> s_ready[2] falls once skid fills, no beat lost or duplicated, output order 0x21..0x24 intact.
- Lock hold: req0 mid-packet drops s_valid for 2 cycles while req3 requests -> grant stays 0 until req0's last beat, then req3 is granted; pointer wraps 3->0 after req3's packet.
- Reset mid-packet: rstn low for 1 cycle during req1's beat 2 of 4 -> next cycle m_valid=0, skid empty, state IDLE, pointer=0; a fresh arbitration then grants the lowest valid index.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
// Round-robin arbiter that shares one valid/ready channel among NREQ
// requesters. Once a requester is granted, the channel stays locked to it
// until its last beat is accepted. The output is registered, and a one-entry
// skid buffer absorbs the beat that is in flight when downstream stalls.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   s_data/s_valid/s_last   per-requester beat (requester i owns slice i)
//   s_ready              per-requester accept, derived from registered state only
//   m_data/m_valid/m_last   shared registered output beat
//   m_ready              downstream accept
//   m_grant              current or most recently granted requester
//   busy                 high while a packet holds the lock
module stream_rr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8,
  parameter int IW     = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ*DWIDTH-1:0] s_data,
  input  logic [NREQ-1:0]        s_valid,
  input  logic [NREQ-1:0]        s_last,
  output logic [NREQ-1:0]        s_ready,
  output logic [DWIDTH-1:0]      m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic [IW-1:0]          m_grant,
  output logic                   busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state;
  logic [IW-1:0]     rr_ptr;
  logic              skid_full;
  logic [DWIDTH-1:0] skid_data;
  logic              skid_last;

  logic [IW-1:0]     sel;
  logic [IW-1:0]     sel_hi;
  logic              found_hi;
  logic [DWIDTH-1:0] acc_data;
  logic              acc_last;
  logic              accept;

  // Round-robin pick without a modulo: the lowest valid index at or above the
  // pointer wins; if there is none, the search wraps to the lowest valid index
  // overall. The loop runs downward so the last assignment is the lowest index.
  always_comb begin
    sel      = '0;
    sel_hi   = '0;
    found_hi = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (s_valid[i]) begin
        sel = IW'(i);
        if (IW'(i) >= rr_ptr) begin
          sel_hi   = IW'(i);
          found_hi = 1'b1;
        end
      end
    end
    if (found_hi) begin
      sel = sel_hi;
    end
  end

  // Only the granted requester can be ready, and never while the skid holds a
  // beat. This keeps at most one beat in flight beyond the output register.
  always_comb begin
    s_ready  = '0;
    acc_data = '0;
    acc_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (m_grant == IW'(i)) begin
        s_ready[i] = (state == LOCK) && !skid_full;
        acc_data   = s_data[i*DWIDTH +: DWIDTH];
        acc_last   = s_last[i];
      end
    end
  end

  assign accept = |(s_valid & s_ready);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      m_grant   <= '0;
      busy      <= 1'b0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_valid) begin
            m_grant <= sel;
            state   <= LOCK;
            busy    <= 1'b1;
          end
        end
        LOCK: begin
          if (accept && acc_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            rr_ptr <= (m_grant == IW'(NREQ - 1)) ? '0 : m_grant + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // The skid entry is older than any newly accepted beat, so it drains first.
      // While it is full s_ready is low, so accept and skid drain never coincide.
      if (!m_valid || m_ready) begin
        if (skid_full) begin
          m_data    <= skid_data;
          m_last    <= skid_last;
          m_valid   <= 1'b1;
          skid_full <= 1'b0;
        end else if (accept) begin
          m_data  <= acc_data;
          m_last  <= acc_last;
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_data <= acc_data;
        skid_last <= acc_last;
        skid_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter
// Self-checking bench for stream_rr_arbiter. The reference model treats the
// output side as a plain two-deep FIFO, and arbitration as "first valid
// requester at or after the pointer". Accepted beats go into a scoreboard
// queue, and an independent monitor pops them as the DUT delivers beats.
module tb_stream_rr_arbiter;

  localparam int NREQ   = 4;
  localparam int DWIDTH = 8;
  localparam int IW     = 2;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic [NREQ*DWIDTH-1:0] s_data = '0;
  logic [NREQ-1:0]        s_valid = '0;
  logic [NREQ-1:0]        s_last = '0;
  logic [NREQ-1:0]        s_ready;
  logic [DWIDTH-1:0]      m_data;
  logic                   m_valid;
  logic                   m_last;
  logic                   m_ready = 1'b0;
  logic [IW-1:0]          m_grant;
  logic                   busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DWIDTH-1:0] data;
    logic              last;
  } beat_t;

  // Reference model state: the lock, the grant and the pointer as plain
  // integers, plus the output path as a FIFO of at most two beats.
  beat_t mfifo[$];
  beat_t sb[$];
  bit    mlock = 1'b0;
  int    mgrant = 0;
  int    mptr = 0;

  // Per-requester packet generators.
  int          pkt_len[NREQ];
  int          beat_cnt[NREQ];
  int          pkts_left[NREQ];
  logic [7:0]  nxt_data[NREQ];
  bit          rand_len = 1'b0;

  stream_rr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .IW(IW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_ready (m_ready),
    .m_grant (m_grant),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and reports it if the values differ.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Resets every generator to an idle state, with no packets pending.
  task automatic clearGen();
    for (int i = 0; i < NREQ; i++) begin
      pkt_len[i]   = 1;
      beat_cnt[i]  = 0;
      pkts_left[i] = 0;
      nxt_data[i]  = '0;
    end
  endtask

  // A single clock cycle. The task checks the DUT outputs that the last edge
  // produced against the model, drives new inputs, and advances the model to
  // the state it expects after the coming edge.
  task automatic applyStimulus(input logic [NREQ-1:0] mask, input logic rdy, input logic rst_n);
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] l;
    beat_t           b;
    bit              acc;
    bit              found;
    int              c;
    @(negedge clk);
    exp_ready = '0;
    if (mlock && mfifo.size() < 2) exp_ready = NREQ'(1) << mgrant;
    checkOutput("s_ready", 32'(s_ready), 32'(exp_ready));
    checkOutput("m_valid", 32'(m_valid), 32'(mfifo.size() > 0));
    checkOutput("busy", 32'(busy), 32'(mlock));
    checkOutput("m_grant", 32'(m_grant), 32'(mgrant));

    v = '0;
    l = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((((mask >> i) & 1) != 0) && pkts_left[i] > 0) v = v | (NREQ'(1) << i);
      if (beat_cnt[i] == pkt_len[i] - 1) l = l | (NREQ'(1) << i);
      s_data[i*DWIDTH +: DWIDTH] = nxt_data[i];
    end
    s_valid = v;
    s_last  = l;
    rstn    = rst_n;
    m_ready = rdy;

    if (!rst_n) begin
      mlock  = 1'b0;
      mgrant = 0;
      mptr   = 0;
      mfifo.delete();
      sb.delete();
    end else begin
      acc = mlock && (((v >> mgrant) & 1) != 0) && mfifo.size() < 2;
      if (mfifo.size() > 0 && rdy) void'(mfifo.pop_front());
      if (acc) begin
        b.data = nxt_data[mgrant];
        b.last = (((l >> mgrant) & 1) != 0);
        mfifo.push_back(b);
        sb.push_back(b);
        beat_cnt[mgrant]++;
        nxt_data[mgrant] = nxt_data[mgrant] + 8'd1;
        if (b.last) begin
          beat_cnt[mgrant] = 0;
          pkts_left[mgrant]--;
          if (rand_len) pkt_len[mgrant] = $urandom_range(1, 4);
          mlock = 1'b0;
          mptr  = (mgrant + 1) % NREQ;
        end
      end else if (!mlock && v != '0) begin
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          c = (mptr + k) % NREQ;
          if (!found && (((v >> c) & 1) != 0)) begin
            found  = 1'b1;
            mgrant = c;
            mlock  = 1'b1;
          end
        end
      end
    end
  endtask

  // Monitor: it runs just after the driver and before the next rising edge.
  // When a downstream transfer is about to happen, the monitor checks the beat
  // against the oldest entry in the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rstn === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL extra_beat: got data=%0h want=none at %0t", m_data, $time);
        end else begin
          e = sb.pop_front();
          checkOutput("m_data", 32'(m_data), 32'(e.data));
          checkOutput("m_last", 32'(m_last), 32'(e.last));
        end
      end
    end
  end

  // Directed scenarios first, then a long randomized run, then a drain.
  initial begin
    clearGen();

    // Reset, followed by a long idle stretch.
    applyStimulus('0, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) applyStimulus('0, 1'b1, 1'b1);

    // Requester 1 sends a single three-beat packet.
    pkt_len[1] = 3; nxt_data[1] = 8'hA1; pkts_left[1] = 1;
    for (int n = 0; n < 8; n++) applyStimulus(4'b0010, 1'b1, 1'b1);

    // Fairness: all four requesters send one-beat packets starting from reset.
    clearGen();
    applyStimulus('0, 1'b1, 1'b0);
    for (int i = 0; i < NREQ; i++) begin
      nxt_data[i]  = 8'(i * 16);
      pkts_left[i] = 2;
    end
    for (int n = 0; n < 20; n++) applyStimulus(4'b1111, 1'b1, 1'b1);

    // Backpressure in the middle of a requester-2 packet.
    clearGen();
    applyStimulus('0, 1'b1, 1'b0);
    pkt_len[2] = 4; nxt_data[2] = 8'h21; pkts_left[2] = 1;
    for (int n = 0; n < 12; n++) applyStimulus(4'b0100, !(n >= 3 && n <= 5), 1'b1);

    // Requester 0 keeps the lock while it drops valid; requester 3 waits.
    clearGen();
    applyStimulus('0, 1'b1, 1'b0);
    pkt_len[0] = 4; nxt_data[0] = 8'h01; pkts_left[0] = 1;
    pkt_len[3] = 2; nxt_data[3] = 8'h31; pkts_left[3] = 1;
    for (int n = 0; n < 3; n++) applyStimulus(4'b1001, 1'b1, 1'b1);
    for (int n = 0; n < 2; n++) applyStimulus(4'b1000, 1'b1, 1'b1);
    for (int n = 0; n < 10; n++) applyStimulus(4'b1001, 1'b1, 1'b1);

    // Reset arrives in the middle of a requester-1 packet.
    clearGen();
    applyStimulus('0, 1'b1, 1'b0);
    pkt_len[1] = 4; nxt_data[1] = 8'h41; pkts_left[1] = 1;
    pkt_len[2] = 1; nxt_data[2] = 8'h51; pkts_left[2] = 1;
    for (int n = 0; n < 3; n++) applyStimulus(4'b0110, 1'b1, 1'b1);
    applyStimulus(4'b0110, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) applyStimulus(4'b0110, 1'b1, 1'b1);

    // Randomized traffic, stalls and occasional resets.
    clearGen();
    applyStimulus('0, 1'b1, 1'b0);
    rand_len = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      pkt_len[i]   = $urandom_range(1, 4);
      nxt_data[i]  = 8'(i * 64);
      pkts_left[i] = 100000;
    end
    for (int n = 0; n < 2000; n++)
      applyStimulus(NREQ'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);

    // Drain, then confirm that every accepted beat came out.
    for (int n = 0; n < 6; n++) applyStimulus('0, 1'b1, 1'b1);
    @(negedge clk);
    #3;
    checkOutput("drain_sb", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
